instr_mem_prefetch: RTL

Parametrised synchronous-read instruction ROM with an autonomous sequential prefetcher and a small instruction queue. It sits between the PC/branch logic and the IF/ID pipeline register. It fetches word-aligned instructions ahead of the consumer and flushes on redirect (branch/jump). Successor to the combinational 1K-word ROM: it adds generic depth and width, registered reads, a valid/ready output and redirect handling.

---
 rtl/instr_mem_pkg.sv | 18 +
 rtl/prefetch_fifo.sv | 70 +++++++
 rtl/instr_mem_prefetch.sv | 116 +++++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-side fetch path.
package instr_mem_pkg;

    // All-zero word; decodes as a MIPS nop.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_BITS  = 10;

    // One queued fetch: error flag, byte address, instruction word.
    // Modules built with a non-default width declare the same layout locally.
    typedef struct packed {
        logic                          err;
        logic [31:0]                   addr;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Generic synchronous FIFO with push, pop, flush and occupancy count.
// DEPTH must be a power of two (pointers wrap naturally).
module prefetch_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Next pointers and count; flush empties the queue and overrides push/pop.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        do_push  = push && !flush && (count_q != CNT_W'(DEPTH));
        do_pop   = pop  && !flush && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write port.
    // NOTE: storage is not reset; the count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);

endmodule

// File: rtl/instr_mem_prefetch.sv
// Instruction ROM with an autonomous sequential prefetcher and a small queue.
// Flow: issue (ROM read) -> read register -> queue -> consumer.
// Optional macro INSTR_MEM_BOUNDS_CHECK_EN: fetches above the ROM range return
// a nop with the error flag set instead of wrapping silently.
module instr_mem_prefetch
    import instr_mem_pkg::*;
#(
    parameter int          DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int          ADDR_BITS  = DEFAULT_ADDR_BITS,
    parameter int          FIFO_DEPTH = 4,
    parameter string       INIT_FILE  = "",
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Redirect,
    input  logic [31:0]           Redirect_Addr,
    input  logic                  Instr_Ready,
    output logic                  Instr_Valid,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic [31:0]           Instr_Addr,
    output logic                  Instr_Err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic                  err;
        logic [31:0]           addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [31:0]           pc_q, pc_d;
    logic                  rd_valid_q, rd_valid_d;
    entry_t                rd_entry_q, rd_entry_d;
    logic [ADDR_BITS-1:0]  rom_idx;
    logic [DATA_WIDTH-1:0] rom_word;
    logic                  fetch_err;
    entry_t                fetch_entry;
    logic                  issue;
    entry_t                head;
    logic [CNT_W-1:0]      q_count;
    logic                  q_empty;
    logic                  q_pop;

    // Upper PC bits are dropped, so the ROM index wraps modulo its depth.
    assign rom_idx = pc_q[ADDR_BITS+1:2];

    // ROM image: word i holds i*3.
    assign rom_word = DATA_WIDTH'(rom_idx) * DATA_WIDTH'(3);

`ifdef INSTR_MEM_BOUNDS_CHECK_EN
    assign fetch_err = ((pc_q >> (ADDR_BITS + 2)) != 32'd0);
`else
    assign fetch_err = 1'b0;
`endif

    assign fetch_entry.err  = fetch_err;
    assign fetch_entry.addr = pc_q;
    assign fetch_entry.data = fetch_err ? DATA_WIDTH'(NOP_INSTR) : rom_word;

    // Issue only when every outstanding fetch is guaranteed a queue slot;
    // a pop in the same cycle is deliberately not counted as free space.
    assign issue = !Redirect &&
                   ((int'(q_count) + int'(rd_valid_q)) < FIFO_DEPTH);

    // Next PC and read-stage contents; a redirect reloads the PC and drops the read stage.
    always_comb begin
        pc_d       = pc_q;
        rd_valid_d = issue;
        rd_entry_d = rd_entry_q;
        if (Redirect) begin
            pc_d = Redirect_Addr & ~32'h3;
        end else if (issue) begin
            pc_d       = pc_q + 32'd4;
            rd_entry_d = fetch_entry;
        end
    end

    // PC and read-stage registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc_q       <= RESET_PC & ~32'h3;
            rd_valid_q <= 1'b0;
            rd_entry_q <= '0;
        end else begin
            pc_q       <= pc_d;
            rd_valid_q <= rd_valid_d;
            rd_entry_q <= rd_entry_d;
        end
    end

    assign q_pop = Instr_Valid && Instr_Ready;

    prefetch_fifo #(
        .WIDTH (DATA_WIDTH + 33),
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .flush     (Redirect),
        .push      (rd_valid_q && !Redirect),
        .push_data (rd_entry_q),
        .pop       (q_pop),
        .head_data (head),
        .count     (q_count),
        .empty     (q_empty)
    );

    // Outputs read as zero whenever the queue is empty.
    assign Instr_Valid = !q_empty;
    assign Instruction = q_empty ? '0    : head.data;
    assign Instr_Addr  = q_empty ? 32'd0 : head.addr;
    assign Instr_Err   = !q_empty && head.err;

endmodule
